// File: rtl/req_enc_pkg.sv
// req_enc_pkg: shared sizes, FSM state type and index decode helper
package req_enc_pkg;
   localparam int REQ_N = 8;
   localparam int IDX_W = 3;
   typedef enum logic {IDLE, PRESENT} state_t;
   function automatic logic [REQ_N-1:0] onehot8(input logic [IDX_W-1:0] idx);
      return REQ_N'(1) << idx;
   endfunction
endpackage

// File: rtl/prio_enc8.sv
// prio_enc8: combinational 8-to-3 encoder, highest set index wins
module prio_enc8
   import req_enc_pkg::*;
(
   input  logic [REQ_N-1:0] i_cand,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);
   // scan upward so the highest set bit is the last one written
   always_comb begin
      o_idx = '0;
      o_any = |i_cand;
      for (int i = 0; i < REQ_N; i++)
         if (i_cand[i]) o_idx = IDX_W'(i);
   end
endmodule

// File: rtl/req_capture_encoder.sv
// req_capture_encoder: captures request events into pending bits and hands out the highest unmasked index
module req_capture_encoder
   import req_enc_pkg::*;
#(
   parameter bit EDGE = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REQ_N-1:0] req_in,
   input  logic [REQ_N-1:0] mask,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [REQ_N-1:0] pending,
   output logic             overflow,
   input  logic             clr_overflow
);
   logic [REQ_N-1:0] r_prev, r_pending, w_ev, w_clr, w_cand;
   logic [IDX_W-1:0] r_idx, w_sel, w_idx_nxt;
   logic             r_valid, r_overflow, w_hs, w_any, w_ovf_set, w_load, w_valid_nxt;
   state_t           r_state, w_state_nxt;

   assign w_ev      = EDGE ? (req_in & ~r_prev) : req_in;
   assign w_hs      = r_valid && out_ready;
   assign w_clr     = w_hs ? onehot8(r_idx) : '0;
   assign w_cand    = r_pending & mask & ~w_clr;
   assign w_ovf_set = EDGE && |(w_ev & r_pending & ~w_clr);

   prio_enc8 u_enc (.i_cand(w_cand), .o_idx(w_sel), .o_any(w_any));

   // edge history (reset loads current lines so held-high requests are not events), pending and sticky overflow
   always_ff @(posedge clk) begin
      r_prev     <= req_in;
      r_pending  <= rst ? '0 : ((r_pending & ~w_clr) | w_ev);
      r_overflow <= rst ? 1'b0 : (w_ovf_set || (r_overflow && !clr_overflow));
   end

   // state register
   always_ff @(posedge clk) r_state <= rst ? IDLE : w_state_nxt;

   // next state: leave PRESENT only when the accepted index leaves nothing eligible
   always_comb w_state_nxt = (r_state == IDLE) ? (w_any ? PRESENT : IDLE) : ((w_hs && !w_any) ? IDLE : PRESENT);

   // output decode: a new index is loaded only from IDLE or on a handshake, never preempting
   always_comb begin
      w_load      = w_any && (r_state == IDLE || w_hs);
      w_idx_nxt   = w_load ? w_sel : r_idx;
      w_valid_nxt = (w_state_nxt == PRESENT);
   end

   // registered presentation to the consumer
   always_ff @(posedge clk) begin
      r_valid <= rst ? 1'b0 : w_valid_nxt;
      r_idx   <= rst ? '0 : w_idx_nxt;
   end

   assign out_valid = r_valid;
   assign out_idx   = r_idx;
   assign pending   = r_pending;
   assign overflow  = r_overflow;
endmodule

// File: tb/tb_req_capture_encoder.sv
// tb_req_capture_encoder: vector table with scoreboard queue, plus a level-capture sequence
module tb_req_capture_encoder;
   logic       clk = 1'b0, rst = 1'b1, out_ready = 1'b1, clr_overflow = 1'b0;
   logic [7:0] req_in = '0, mask = 8'hFF, l_req = '0;
   logic       out_valid, overflow, l_valid, l_overflow;
   logic [2:0] out_idx, l_idx;
   logic [7:0] pending, l_pending;
   int         n_cmp = 0, n_bad = 0;

   typedef struct {
      logic       rst;
      logic [7:0] req, msk;
      logic       rdy, clro;
      logic       v;
      logic [2:0] i;
      logic [7:0] p;
      logic       o;
   } vec_t;
   typedef struct {
      logic       v;
      logic [2:0] i;
      logic [7:0] p;
      logic       o;
   } exp_t;
   vec_t tbl[$];
   exp_t sb[$];

   req_capture_encoder #(.EDGE(1'b1)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .out_valid(out_valid),
      .out_ready(out_ready), .out_idx(out_idx), .pending(pending), .overflow(overflow),
      .clr_overflow(clr_overflow)
   );
   req_capture_encoder #(.EDGE(1'b0)) dut_lvl (
      .clk(clk), .rst(rst), .req_in(l_req), .mask(mask), .out_valid(l_valid),
      .out_ready(out_ready), .out_idx(l_idx), .pending(l_pending), .overflow(l_overflow),
      .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   task automatic add(input logic r, input logic [7:0] q, input logic [7:0] m, input logic rd, input logic co,
                      input logic v, input logic [2:0] i, input logic [7:0] p, input logic o);
      tbl.push_back('{r, q, m, rd, co, v, i, p, o});
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   initial begin
      exp_t e;
      bit   seen;
      //   rst req   mask  rdy clro | v idx pend  ovf
      add(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 0);
      add(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 0);
      add(0, 8'h04, 8'hFF, 1, 0, 0, 0, 8'h04, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 1, 2, 8'h04, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 0, 2, 8'h00, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 0, 2, 8'h00, 0);
      add(0, 8'h91, 8'hFF, 1, 0, 0, 2, 8'h91, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 1, 7, 8'h91, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 1, 4, 8'h11, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 1, 0, 8'h01, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 0);
      add(0, 8'h02, 8'hFF, 0, 0, 0, 0, 8'h02, 0);
      add(0, 8'h00, 8'hFF, 0, 0, 1, 1, 8'h02, 0);
      add(0, 8'h80, 8'hFF, 0, 0, 1, 1, 8'h82, 0);
      add(0, 8'h00, 8'h00, 0, 0, 1, 1, 8'h82, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 1, 7, 8'h80, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 0, 7, 8'h00, 0);
      add(0, 8'h30, 8'h10, 1, 0, 0, 7, 8'h30, 0);
      add(0, 8'h00, 8'h10, 1, 0, 1, 4, 8'h30, 0);
      add(0, 8'h00, 8'h10, 1, 0, 0, 4, 8'h20, 0);
      add(0, 8'h00, 8'h10, 1, 0, 0, 4, 8'h20, 0);
      add(0, 8'h00, 8'h30, 1, 0, 1, 5, 8'h20, 0);
      add(0, 8'h00, 8'h30, 1, 0, 0, 5, 8'h00, 0);
      add(0, 8'h08, 8'hFF, 0, 0, 0, 5, 8'h08, 0);
      add(0, 8'h00, 8'hFF, 0, 0, 1, 3, 8'h08, 0);
      add(0, 8'h08, 8'hFF, 0, 0, 1, 3, 8'h08, 1);
      add(0, 8'h00, 8'hFF, 0, 1, 1, 3, 8'h08, 0);
      add(0, 8'h08, 8'hFF, 1, 0, 0, 3, 8'h08, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 1, 3, 8'h08, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 0, 3, 8'h00, 0);
      add(0, 8'h01, 8'hFF, 0, 0, 0, 3, 8'h01, 0);
      add(0, 8'h00, 8'hFF, 0, 0, 1, 0, 8'h01, 0);
      add(0, 8'h01, 8'hFF, 0, 1, 1, 0, 8'h01, 1);
      add(0, 8'h00, 8'hFF, 0, 1, 1, 0, 8'h01, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 0);
      add(1, 8'h40, 8'hFF, 1, 0, 0, 0, 8'h00, 0);
      add(0, 8'h40, 8'hFF, 1, 0, 0, 0, 8'h00, 0);
      add(0, 8'h40, 8'hFF, 1, 0, 0, 0, 8'h00, 0);
      add(0, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h00, 0);
      add(0, 8'h02, 8'hFF, 0, 0, 0, 0, 8'h02, 0);
      add(0, 8'h00, 8'hFF, 0, 0, 1, 1, 8'h02, 0);
      add(1, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0);
      add(0, 8'h00, 8'hFF, 0, 0, 0, 0, 8'h00, 0);

      foreach (tbl[k]) begin
         @(negedge clk);
         rst = tbl[k].rst; req_in = tbl[k].req; mask = tbl[k].msk;
         out_ready = tbl[k].rdy; clr_overflow = tbl[k].clro;
         sb.push_back('{tbl[k].v, tbl[k].i, tbl[k].p, tbl[k].o});
         @(posedge clk);
         #1;
         e = sb.pop_front();
         n_cmp++;
         if ({out_valid, out_idx, pending, overflow} !== {e.v, e.i, e.p, e.o}) begin
            n_bad++;
            $display("FAIL vec%0d: got v=%b idx=%0d pend=%h ovf=%b want v=%b idx=%0d pend=%h ovf=%b",
                     k, out_valid, out_idx, pending, overflow, e.v, e.i, e.p, e.o);
         end
      end

      @(negedge clk);
      rst = 1'b1; l_req = '0; mask = 8'hFF; out_ready = 1'b1; clr_overflow = 1'b0;
      @(negedge clk);
      rst = 1'b0; l_req = 8'h04;
      @(posedge clk); #1;
      chk("lvl_pend", {24'd0, l_pending}, 32'h04);
      chk("lvl_valid0", {31'd0, l_valid}, 32'd0);
      @(posedge clk); #1;
      chk("lvl_present", {28'd0, l_valid, l_idx}, {28'd0, 1'b1, 3'd2});
      @(posedge clk); #1;
      chk("lvl_reset_after_hs", {22'd0, l_valid, l_pending, l_overflow}, {22'd0, 1'b0, 8'h04, 1'b0});
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
         @(posedge clk); #1;
         seen = l_valid;
      end
      chk("lvl_represent", {28'd0, seen, l_idx}, {28'd0, 1'b1, 3'd2});
      chk("lvl_ovf_tied", {31'd0, l_overflow}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/req_capture_encoder.md
# req_capture_encoder

Captures event pulses on eight request lines into a pending register, selects the highest-index pending and unmasked request, and presents its 3-bit index to the consumer over a valid/ready handshake. The block sits directly upstream of the index consumers: downstream interrupt and dispatch logic receives an already-encoded, registered index instead of raw request lines. The accepted request's pending bit is cleared on handshake.

## Interface
- `EDGE`, default 1. 1 = rising-edge capture of `req_in`. 0 = level capture.
- `clk` input 1. Single clock; everything is rising-edge.
- `rst` input 1. Synchronous, active-high reset.
- `req_in` input 8. Raw request lines, synchronous to `clk`.
- `mask` input 8. 1 = line eligible for selection. Masked lines still accumulate in `pending`.
- `out_valid` output 1. A registered index is presented.
- `out_ready` input 1. Consumer accepts when `out_valid && out_ready`.
- `out_idx` output 3. Index of the presented request, with 7 as the highest priority.
- `pending` output 8. Current pending register.
- `overflow` output 1. Sticky flag: an event was lost (EDGE=1 only).
- `clr_overflow` input 1. Clears `overflow`.

## Operation
- **Event detect**
  - `prev` register holds last `req_in`.
  - EDGE=1: `ev = req_in & ~prev`.
  - EDGE=0: `ev = req_in`.
- **Pending update, every cycle:** `pending <= (pending & ~clr_vec) | ev`.
  - `clr_vec` is onehot(`out_idx`) on the handshake cycle, else 0.
  - Set wins over clear: an event on the bit being accepted in the same cycle leaves that bit pending.
- **Overflow (EDGE=1)**
  - Set when any `ev[i]` hits a bit with `pending[i]=1` that is not being cleared that cycle.
  - Set wins over `clr_overflow` in the same cycle.
  - EDGE=0: `overflow` is tied 0.
- **Selection:** `sel` is the highest set bit of `cand`.
  - In IDLE, `cand = pending & mask`.
  - On the handshake cycle, `cand = pending & mask & ~clr_vec`.
  - `any = |cand`.
- **FSM states:** IDLE and PRESENT.
  - IDLE, `any=1`: load `out_idx <= sel`, `out_valid <= 1`, go to PRESENT.
  - IDLE, `any=0`: stay in IDLE. `out_idx` holds its last value.
  - PRESENT without handshake: `out_idx` and `out_valid` are held stable. Changes to `mask` or new higher-priority events do not preempt the presented index.
  - PRESENT with handshake and `any=1`: load the next `sel`, keep `out_valid=1`, stay in PRESENT (back-to-back).
  - PRESENT with handshake and `any=0`: `out_valid <= 0`, go to IDLE.
- **Masking:** an index in PRESENT stays presented even if its mask bit is cleared. The mask affects only new selections.
- **Reset:**
  - `pending=0`, `out_valid=0`, `out_idx=0`, `overflow=0`, state IDLE.
  - `prev <= req_in` during reset, so lines already high at reset release do not produce events.
- **Reset mid-operation:** a presented index is dropped without handshake and all pending events are discarded.

## Timing
- **Latency:** edge on `req_in` sampled at edge N → `pending` bit set after edge N → `out_valid=1` after edge N+1. Two cycles from the request edge to a valid index.
- **Throughput:** one index per cycle while the consumer holds `out_ready=1` and requests remain pending.
- **First selection after IDLE:** uses `pending` as registered. An event arriving in the same cycle is considered the next cycle.
- **Outputs:** `out_valid`, `out_idx`, `pending` and `overflow` are all registered, with no combinational path from inputs.
- **Ready independence:** `out_valid` does not depend on `out_ready`. The consumer may hold `out_ready` high permanently.

## Structure
- **Package `req_enc_pkg`:**
  - `REQ_N=8`, `IDX_W=3`.
  - State enum `{IDLE, PRESENT}`.
  - Function `onehot8(idx)`.
- **Sub-module `prio_enc8`:** combinational 8→3 highest-index priority encoder with an `any` output. Instantiated once on `cand`.
- **Top level:** edge detect, pending and overflow registers, FSM and output registers.

## Test plan
- **Single event:** pulse `req_in=8'h04` for one cycle, `mask=8'hFF`, `out_ready=1`. Expect `out_valid` 2 cycles later with `out_idx=2`, `pending` back to 0 after the handshake, then `out_valid=0`.
- **Back-to-back priority drain:** simultaneous events `8'h91`, `out_ready=1`. Expect `out_idx` 7, 4, 0 on consecutive cycles, then `out_valid=0`.
- **Stall stability:** events `8'h02`, then `8'h80` while `out_ready=0`. Expect `out_idx=1` held stable until ready, then 7 presented next.
- **Masking:** events `8'h30` with `mask=8'h10`. Expect only `out_idx=4`; `pending=8'h20` remains. Setting `mask[5]` then yields `out_idx=5`.
- **Overflow and set-over-clear:**
  - A second rising edge on bit 3 before acceptance sets `overflow=1`. `clr_overflow` returns it to 0.
  - A rising edge on bit 3 in the same cycle as accepting index 3 leaves `pending[3]=1` and `overflow=0`.
- **Reset handling:**
  - Hold `req_in[6]=1` through reset release. Expect no event.
  - Assert `rst` while `out_valid=1`. Expect `out_valid=0` and `pending=0` on the next cycle.
